// File: rtl/mem_stage.sv
// MEM pipeline stage: issues one aligned data-memory access per load/store,
// formats byte lanes, and hands results to MEM/WB with a one-cycle out_valid pulse.
module mem_stage #(
    parameter int PC_WIDTH     = 64,
    parameter int REG_WIDTH    = 64,
    parameter int REG_COUNT    = 32,
    parameter int M_Ctrl_bits  = 5,
    parameter int WB_Ctrl_bits = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WB_Ctrl_bits-1:0]      WB_Ctrl_in,
    input  logic [M_Ctrl_bits-1:0]       M_Ctrl_in,
    input  logic [PC_WIDTH-1:0]          PC_in,
    input  logic [REG_WIDTH-1:0]         ALU_res_in,
    input  logic [REG_WIDTH-1:0]         rs2_data_in,
    input  logic [$clog2(REG_COUNT)-1:0] rd_addr_in,
    output logic                         mem_req_valid,
    input  logic                         mem_req_ready,
    output logic                         mem_we,
    output logic [REG_WIDTH-1:0]         mem_addr,
    output logic [63:0]                  mem_wdata,
    output logic [7:0]                   mem_wstrb,
    input  logic                         mem_resp_valid,
    input  logic [63:0]                  mem_rdata,
    output logic                         out_valid,
    output logic [WB_Ctrl_bits-1:0]      WB_Ctrl_out,
    output logic [PC_WIDTH-1:0]          PC_out,
    output logic [REG_WIDTH-1:0]         ALU_res_out,
    output logic [63:0]                  load_data_out,
    output logic [$clog2(REG_COUNT)-1:0] rd_addr_out,
    output logic                         misaligned_out,
    output logic                         stall_out,
    output logic [1:0]                   state_out
);
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

    state_t state, state_next;

    logic [2:0]  f3_in, lane_in;
    logic        rd_in, wr_in, mem_op_in, mis_in, accept;
    logic [7:0]  size_mask_in;
    logic [63:0] byte_mask_in, wdata_in;

    logic [WB_Ctrl_bits-1:0]      wb_q;
    logic [PC_WIDTH-1:0]          pc_q;
    logic [REG_WIDTH-1:0]         alu_q;
    logic [$clog2(REG_COUNT)-1:0] rd_q;
    logic [2:0]                   f3_q;
    logic                         is_load_q;
    logic [63:0]                  shifted, load_fmt;

    assign f3_in     = M_Ctrl_in[4:2];
    assign rd_in     = M_Ctrl_in[0];
    assign wr_in     = M_Ctrl_in[1];
    assign mem_op_in = rd_in | wr_in;
    assign lane_in   = ALU_res_in[2:0];
    assign accept    = (state == IDLE) && in_valid;

    always_comb begin
        mis_in       = 1'b0;
        size_mask_in = 8'h01;
        byte_mask_in = 64'h0000_0000_0000_00FF;
        case (f3_in[1:0])
            2'b00: ;
            2'b01: begin
                mis_in       = lane_in[0];
                size_mask_in = 8'h03;
                byte_mask_in = 64'h0000_0000_0000_FFFF;
            end
            2'b10: begin
                mis_in       = (lane_in[1:0] != 2'b00);
                size_mask_in = 8'h0F;
                byte_mask_in = 64'h0000_0000_FFFF_FFFF;
            end
            default: begin
                mis_in       = (lane_in != 3'b000);
                size_mask_in = 8'hFF;
                byte_mask_in = 64'hFFFF_FFFF_FFFF_FFFF;
            end
        endcase
    end

    assign wdata_in = (rs2_data_in[63:0] & byte_mask_in) << {lane_in, 3'b000};

    // Load formatting always works from the captured address/funct3, never the live inputs.
    assign shifted = mem_rdata >> {alu_q[2:0], 3'b000};

    always_comb begin
        load_fmt = shifted;
        case (f3_q[1:0])
            2'b00:   load_fmt = {{56{~f3_q[2] & shifted[7]}},  shifted[7:0]};
            2'b01:   load_fmt = {{48{~f3_q[2] & shifted[15]}}, shifted[15:0]};
            2'b10:   load_fmt = {{32{~f3_q[2] & shifted[31]}}, shifted[31:0]};
            default: load_fmt = shifted;
        endcase
    end

    // Request handshake: mem_req_valid rises in REQ and stays high with address/data/strobe/we
    // frozen until the edge where mem_req_valid & mem_req_ready; that edge completes the transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next    = state;
        in_ready      = 1'b0;
        mem_req_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid && mem_op_in && !mis_in) state_next = REQ;
            end
            REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) state_next = WAIT;
            end
            WAIT: begin
                if (mem_resp_valid) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign stall_out = in_valid & ~in_ready;
    assign state_out = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_q           <= '0;
            pc_q           <= '0;
            alu_q          <= '0;
            rd_q           <= '0;
            f3_q           <= '0;
            is_load_q      <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            mem_wstrb      <= '0;
            out_valid      <= 1'b0;
            WB_Ctrl_out    <= '0;
            PC_out         <= '0;
            ALU_res_out    <= '0;
            load_data_out  <= '0;
            rd_addr_out    <= '0;
            misaligned_out <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (accept) begin
                if (mem_op_in && !mis_in) begin
                    wb_q      <= WB_Ctrl_in;
                    pc_q      <= PC_in;
                    alu_q     <= ALU_res_in;
                    rd_q      <= rd_addr_in;
                    f3_q      <= f3_in;
                    is_load_q <= rd_in;
                    mem_addr  <= {ALU_res_in[REG_WIDTH-1:3], 3'b000};
                    // A read+write combination is treated as a plain load.
                    mem_we    <= wr_in & ~rd_in;
                    mem_wdata <= rd_in ? 64'd0 : wdata_in;
                    mem_wstrb <= rd_in ? 8'd0 : (size_mask_in << lane_in);
                end else begin
                    out_valid      <= 1'b1;
                    WB_Ctrl_out    <= mem_op_in ? '0 : WB_Ctrl_in;
                    PC_out         <= PC_in;
                    ALU_res_out    <= ALU_res_in;
                    rd_addr_out    <= rd_addr_in;
                    load_data_out  <= '0;
                    misaligned_out <= mem_op_in;
                end
            end else if (state == WAIT && mem_resp_valid) begin
                out_valid      <= 1'b1;
                WB_Ctrl_out    <= wb_q;
                PC_out         <= pc_q;
                ALU_res_out    <= alu_q;
                rd_addr_out    <= rd_q;
                load_data_out  <= is_load_q ? load_fmt : 64'd0;
                misaligned_out <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, load/store lane formatting,
// misaligned faults, memory stalls and reset abort.
module tb_mem_stage;
    logic        clk, rst, in_valid, in_ready;
    logic [4:0]  WB_Ctrl_in, M_Ctrl_in;
    logic [63:0] PC_in, ALU_res_in, rs2_data_in;
    logic [4:0]  rd_addr_in;
    logic        mem_req_valid, mem_req_ready, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        mem_resp_valid;
    logic [63:0] mem_rdata;
    logic        out_valid;
    logic [4:0]  WB_Ctrl_out;
    logic [63:0] PC_out, ALU_res_out, load_data_out;
    logic [4:0]  rd_addr_out;
    logic        misaligned_out, stall_out;
    logic [1:0]  state_out;

    int vectors = 0;
    int miscompares = 0;

    mem_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .WB_Ctrl_in(WB_Ctrl_in), .M_Ctrl_in(M_Ctrl_in), .PC_in(PC_in),
        .ALU_res_in(ALU_res_in), .rs2_data_in(rs2_data_in), .rd_addr_in(rd_addr_in),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .WB_Ctrl_out(WB_Ctrl_out), .PC_out(PC_out),
        .ALU_res_out(ALU_res_out), .load_data_out(load_data_out),
        .rd_addr_out(rd_addr_out), .misaligned_out(misaligned_out),
        .stall_out(stall_out), .state_out(state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one instruction for exactly one edge; returns 1 time unit after that edge.
    task automatic drive_op(input logic [4:0] wb, input logic [4:0] mc, input logic [63:0] pc,
                            input logic [63:0] alu, input logic [63:0] rs2, input logic [4:0] rd);
        WB_Ctrl_in  = wb;
        M_Ctrl_in   = mc;
        PC_in       = pc;
        ALU_res_in  = alu;
        rs2_data_in = rs2;
        rd_addr_in  = rd;
        in_valid    = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Called right after acceptance: snapshots the request, grants it, then responds.
    // Returns 1 time unit after the edge where out_valid should be high.
    task automatic do_mem(input logic [63:0] rdata, output logic rv, output logic we,
                          output logic [63:0] addr, output logic [63:0] wdata,
                          output logic [7:0] wstrb);
        rv    = mem_req_valid;
        we    = mem_we;
        addr  = mem_addr;
        wdata = mem_wdata;
        wstrb = mem_wstrb;
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = rdata;
        @(posedge clk); #1;
        mem_resp_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; WB_Ctrl_in = '0; M_Ctrl_in = '0; PC_in = '0; ALU_res_in = '0;
        rs2_data_in = '0; rd_addr_in = '0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
        vectors++; if (mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL rst_req_valid got %b exp 0", mem_req_valid); end
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL rst_we got %b exp 0", mem_we); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
        vectors++; if (state_out !== 2'd0) begin miscompares++; $display("FAIL rst_state got %0d exp 0", state_out); end
        vectors++; if ({ALU_res_out, load_data_out, PC_out, mem_addr} !== 256'd0) begin miscompares++; $display("FAIL rst_data got %h %h %h %h exp 0", ALU_res_out, load_data_out, PC_out, mem_addr); end
        vectors++; if ({misaligned_out, WB_Ctrl_out, rd_addr_out} !== 11'd0) begin miscompares++; $display("FAIL rst_ctrl got %b %h %h exp 0", misaligned_out, WB_Ctrl_out, rd_addr_out); end
        rst = 1'b0;
    endtask

    task automatic test_alu_op();
        drive_op(5'h15, 5'h00, 64'h8000_0040, 64'h1234, 64'h0, 5'd5);
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL alu_out_valid got %b exp 1", out_valid); end
        vectors++; if (ALU_res_out !== 64'h1234) begin miscompares++; $display("FAIL alu_res got %h exp 1234", ALU_res_out); end
        vectors++; if (rd_addr_out !== 5'd5) begin miscompares++; $display("FAIL alu_rd got %0d exp 5", rd_addr_out); end
        vectors++; if (PC_out !== 64'h8000_0040) begin miscompares++; $display("FAIL alu_pc got %h exp 80000040", PC_out); end
        vectors++; if (WB_Ctrl_out !== 5'h15) begin miscompares++; $display("FAIL alu_wb got %h exp 15", WB_Ctrl_out); end
        vectors++; if ({mem_req_valid, misaligned_out, load_data_out} !== 66'd0) begin miscompares++; $display("FAIL alu_side got %b %b %h exp 0", mem_req_valid, misaligned_out, load_data_out); end
        @(posedge clk); #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL alu_pulse got %b exp 0", out_valid); end
        vectors++; if (ALU_res_out !== 64'h1234) begin miscompares++; $display("FAIL alu_hold got %h exp 1234", ALU_res_out); end
    endtask

    task automatic test_loads();
        logic [4:0]  mc [8];
        logic [63:0] addr [8];
        logic [63:0] rdata [8];
        logic [63:0] exp_ld [8];
        logic rv, we;
        logic [63:0] a, wd;
        logic [7:0] ws;
        mc     = '{5'h01, 5'h11, 5'h05, 5'h05, 5'h09, 5'h19, 5'h0D, 5'h0F};
        addr   = '{64'h1003, 64'h1003, 64'h1002, 64'h1006, 64'h1004, 64'h1004, 64'h1008, 64'h3000};
        rdata  = '{64'h0000_0000_8000_0000, 64'h0000_0000_8000_0000, 64'h0000_0000_7FFF_0000,
                   64'h8001_0000_0000_0000, 64'h8765_4321_0000_0000, 64'h8765_4321_0000_0000,
                   64'hFEDC_BA98_7654_3210, 64'h1122_3344_5566_7788};
        exp_ld = '{64'hFFFF_FFFF_FFFF_FF80, 64'h0000_0000_0000_0080, 64'h0000_0000_0000_7FFF,
                   64'hFFFF_FFFF_FFFF_8001, 64'hFFFF_FFFF_8765_4321, 64'h0000_0000_8765_4321,
                   64'hFEDC_BA98_7654_3210, 64'h1122_3344_5566_7788};
        for (int i = 0; i < 8; i++) begin
            drive_op(5'h15, mc[i], 64'h400 + 64'(i), addr[i], 64'hFFFF_FFFF_FFFF_FFFF, 5'd10);
            do_mem(rdata[i], rv, we, a, wd, ws);
            vectors++; if (rv !== 1'b1) begin miscompares++; $display("FAIL ld%0d_req_valid got %b exp 1", i, rv); end
            vectors++; if (we !== 1'b0) begin miscompares++; $display("FAIL ld%0d_we got %b exp 0", i, we); end
            vectors++; if (a !== (addr[i] & ~64'h7)) begin miscompares++; $display("FAIL ld%0d_addr got %h exp %h", i, a, addr[i] & ~64'h7); end
            vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL ld%0d_out_valid got %b exp 1", i, out_valid); end
            vectors++; if (load_data_out !== exp_ld[i]) begin miscompares++; $display("FAIL ld%0d_data got %h exp %h", i, load_data_out, exp_ld[i]); end
            vectors++; if (ALU_res_out !== addr[i]) begin miscompares++; $display("FAIL ld%0d_alu got %h exp %h", i, ALU_res_out, addr[i]); end
            vectors++; if ({WB_Ctrl_out, misaligned_out} !== {5'h15, 1'b0}) begin miscompares++; $display("FAIL ld%0d_wb got %h %b exp 15 0", i, WB_Ctrl_out, misaligned_out); end
        end
    endtask

    task automatic test_stores();
        logic [4:0]  mc [4];
        logic [63:0] addr [4];
        logic [63:0] rs2 [4];
        logic [63:0] exp_wd [4];
        logic [7:0]  exp_ws [4];
        logic rv, we;
        logic [63:0] a, wd;
        logic [7:0] ws;
        mc     = '{5'h06, 5'h02, 5'h0A, 5'h0E};
        addr   = '{64'h1006, 64'h1005, 64'h1004, 64'h1000};
        rs2    = '{64'h1234_5678_9ABC_BEEF, 64'h0000_0000_0000_00AA, 64'hFFFF_FFFF_1234_5678, 64'h0102_0304_0506_0708};
        exp_wd = '{64'hBEEF_0000_0000_0000, 64'h0000_AA00_0000_0000, 64'h1234_5678_0000_0000, 64'h0102_0304_0506_0708};
        exp_ws = '{8'hC0, 8'h20, 8'hF0, 8'hFF};
        for (int i = 0; i < 4; i++) begin
            drive_op(5'h0A, mc[i], 64'h500, addr[i], rs2[i], 5'd3);
            do_mem(64'hFFFF_FFFF_FFFF_FFFF, rv, we, a, wd, ws);
            vectors++; if ({rv, we} !== 2'b11) begin miscompares++; $display("FAIL st%0d_req got %b%b exp 11", i, rv, we); end
            vectors++; if (a !== 64'h1000) begin miscompares++; $display("FAIL st%0d_addr got %h exp 1000", i, a); end
            vectors++; if (wd !== exp_wd[i]) begin miscompares++; $display("FAIL st%0d_wdata got %h exp %h", i, wd, exp_wd[i]); end
            vectors++; if (ws !== exp_ws[i]) begin miscompares++; $display("FAIL st%0d_wstrb got %h exp %h", i, ws, exp_ws[i]); end
            vectors++; if ({out_valid, load_data_out} !== {1'b1, 64'd0}) begin miscompares++; $display("FAIL st%0d_done got %b %h exp 1 0", i, out_valid, load_data_out); end
        end
    endtask

    task automatic test_misaligned();
        logic [4:0]  mc [3];
        logic [63:0] addr [3];
        mc   = '{5'h09, 5'h0E, 5'h05};
        addr = '{64'h1002, 64'h1004, 64'h1001};
        for (int i = 0; i < 3; i++) begin
            drive_op(5'h1F, mc[i], 64'h600, addr[i], 64'h55, 5'd9);
            vectors++; if ({out_valid, misaligned_out} !== 2'b11) begin miscompares++; $display("FAIL mis%0d_flags got %b%b exp 11", i, out_valid, misaligned_out); end
            vectors++; if (WB_Ctrl_out !== 5'h00) begin miscompares++; $display("FAIL mis%0d_wb got %h exp 0", i, WB_Ctrl_out); end
            vectors++; if ({mem_req_valid, state_out} !== 3'b000) begin miscompares++; $display("FAIL mis%0d_noreq got %b %0d exp 0 0", i, mem_req_valid, state_out); end
            vectors++; if ({ALU_res_out, rd_addr_out} !== {addr[i], 5'd9}) begin miscompares++; $display("FAIL mis%0d_pass got %h %0d exp %h 9", i, ALU_res_out, rd_addr_out, addr[i]); end
            @(posedge clk); #1;
            vectors++; if ({mem_req_valid, out_valid} !== 2'b00) begin miscompares++; $display("FAIL mis%0d_after got %b%b exp 00", i, mem_req_valid, out_valid); end
        end
    endtask

    task automatic test_stall();
        int ov_count;
        drive_op(5'h07, 5'h0D, 64'h700, 64'h2008, 64'h0, 5'd12);
        // Next instruction waits upstream while bogus responses arrive during REQ.
        in_valid = 1'b1; M_Ctrl_in = 5'h00; ALU_res_in = 64'hDEAD;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        for (int k = 0; k < 4; k++) begin
            vectors++; if ({mem_req_valid, mem_we, stall_out, in_ready} !== 4'b1010) begin miscompares++; $display("FAIL stall_req%0d got %b%b%b%b exp 1010", k, mem_req_valid, mem_we, stall_out, in_ready); end
            vectors++; if (mem_addr !== 64'h2008) begin miscompares++; $display("FAIL stall_addr%0d got %h exp 2008", k, mem_addr); end
            vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL stall_ov%0d got %b exp 0", k, out_valid); end
            if (k == 3) begin mem_req_ready = 1'b1; mem_resp_valid = 1'b0; end
            @(posedge clk); #1;
        end
        mem_req_ready = 1'b0;
        for (int j = 0; j < 2; j++) begin
            vectors++; if ({state_out, mem_req_valid, stall_out, out_valid} !== 5'b10010) begin miscompares++; $display("FAIL stall_wait%0d got %0d %b%b%b exp 2 010", j, state_out, mem_req_valid, stall_out, out_valid); end
            @(posedge clk); #1;
        end
        mem_resp_valid = 1'b1; mem_rdata = 64'h0123_4567_89AB_CDEF;
        @(posedge clk); #1;
        in_valid = 1'b0; mem_resp_valid = 1'b0;
        ov_count = out_valid ? 1 : 0;
        vectors++; if (load_data_out !== 64'h0123_4567_89AB_CDEF) begin miscompares++; $display("FAIL stall_data got %h exp 0123456789abcdef", load_data_out); end
        vectors++; if ({ALU_res_out, rd_addr_out, WB_Ctrl_out} !== {64'h2008, 5'd12, 5'h07}) begin miscompares++; $display("FAIL stall_pass got %h %0d %h exp 2008 12 07", ALU_res_out, rd_addr_out, WB_Ctrl_out); end
        for (int j = 0; j < 3; j++) begin
            @(posedge clk); #1;
            if (out_valid) ov_count++;
        end
        vectors++; if (ov_count !== 1) begin miscompares++; $display("FAIL stall_pulses got %0d exp 1", ov_count); end
    endtask

    task automatic test_reset_abort();
        // Reset while the request is still outstanding.
        drive_op(5'h03, 5'h0D, 64'h800, 64'h4000, 64'h0, 5'd4);
        vectors++; if (mem_req_valid !== 1'b1) begin miscompares++; $display("FAIL abort_req_pre got %b exp 1", mem_req_valid); end
        rst = 1'b1; #1;
        vectors++; if ({mem_req_valid, state_out} !== 3'b000) begin miscompares++; $display("FAIL abort_req_drop got %b %0d exp 0 0", mem_req_valid, state_out); end
        @(posedge clk); #1;
        rst = 1'b0;
        // Reset while waiting for the response, then a stale response arrives.
        drive_op(5'h03, 5'h09, 64'h804, 64'h4004, 64'h0, 5'd6);
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        vectors++; if (state_out !== 2'd2) begin miscompares++; $display("FAIL abort_in_wait got %0d exp 2", state_out); end
        rst = 1'b1; #1;
        vectors++; if ({out_valid, mem_req_valid, state_out, in_ready} !== 5'b00001) begin miscompares++; $display("FAIL abort_wait_rst got %b%b %0d %b exp 00 0 1", out_valid, mem_req_valid, state_out, in_ready); end
        @(posedge clk); #1;
        rst = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 64'h7777;
        for (int j = 0; j < 2; j++) begin
            @(posedge clk); #1;
            vectors++; if ({out_valid, state_out, in_ready} !== 4'b0001) begin miscompares++; $display("FAIL abort_late%0d got %b %0d %b exp 0 0 1", j, out_valid, state_out, in_ready); end
        end
        mem_resp_valid = 1'b0;
        // First edge after reset release accepts.
        rst = 1'b1; #1; rst = 1'b0;
        drive_op(5'h01, 5'h00, 64'h900, 64'h55, 64'h0, 5'd7);
        vectors++; if ({out_valid, ALU_res_out} !== {1'b1, 64'h55}) begin miscompares++; $display("FAIL post_rst_accept got %b %h exp 1 55", out_valid, ALU_res_out); end
    endtask

    task automatic test_back_to_back();
        WB_Ctrl_in = 5'h02; M_Ctrl_in = 5'h00; PC_in = 64'hA00; ALU_res_in = 64'h111;
        rs2_data_in = 64'h0; rd_addr_in = 5'd1; in_valid = 1'b1;
        @(posedge clk); #1;
        vectors++; if ({out_valid, ALU_res_out, rd_addr_out} !== {1'b1, 64'h111, 5'd1}) begin miscompares++; $display("FAIL b2b_first got %b %h %0d exp 1 111 1", out_valid, ALU_res_out, rd_addr_out); end
        ALU_res_in = 64'h222; rd_addr_in = 5'd2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        vectors++; if ({out_valid, ALU_res_out, rd_addr_out} !== {1'b1, 64'h222, 5'd2}) begin miscompares++; $display("FAIL b2b_second got %b %h %0d exp 1 222 2", out_valid, ALU_res_out, rd_addr_out); end
        @(posedge clk); #1;
        vectors++; if ({out_valid, ALU_res_out} !== {1'b0, 64'h222}) begin miscompares++; $display("FAIL b2b_idle got %b %h exp 0 222", out_valid, ALU_res_out); end
    endtask

    initial begin
        test_reset();
        test_alu_op();
        test_loads();
        test_stores();
        test_misaligned();
        test_stall();
        test_reset_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Param PC_WIDTH, 64, program-counter width.
REQ-002 Param REG_WIDTH, 64, data and address width.
REQ-003 Param REG_COUNT, 32, register count; rd width = $clog2(REG_COUNT).
REQ-004 Param M_Ctrl_bits, 5, memory-control width: bit0 mem_read, bit1 mem_write, bits[4:2] funct3.
REQ-005 Param WB_Ctrl_bits, 5, write-back control width, opaque pass-through.
REQ-006 clk  in  1  clock; all state changes on rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 in_valid  in  1  EX/MEM register holds a valid instruction.
REQ-009 in_ready  out  1  stage accepts an instruction this cycle.
REQ-010 WB_Ctrl_in / M_Ctrl_in / PC_in / ALU_res_in / rs2_data_in / rd_addr_in  in  per params  EX/MEM register outputs; ALU_res_in is the effective address.
REQ-011 mem_req_valid, mem_req_ready  out/in  1  data-memory request handshake.
REQ-012 mem_we  out  1  request is a store.
REQ-013 mem_addr  out  REG_WIDTH  doubleword-aligned address, bits[2:0] = 0.
REQ-014 mem_wdata  out  64; mem_wstrb  out  8  lane-aligned store data and byte enables.
REQ-015 mem_resp_valid  in  1; mem_rdata  in  64  memory completion and read data.
REQ-016 out_valid  out  1  one-cycle pulse: MEM/WB outputs valid.
REQ-017 WB_Ctrl_out, PC_out, ALU_res_out, load_data_out, rd_addr_out  out  per params  registered results to MEM/WB.
REQ-018 misaligned_out  out  1  access fault flag, valid with out_valid.
REQ-019 stall_out  out  1  in_valid & ~in_ready, to upstream hazard logic.

Function
REQ-020 FSM states IDLE, REQ, WAIT; in_ready = (state == IDLE).
REQ-021 IDLE, in_valid, no memory op: outputs load next edge, out_valid = 1 (latency 1), load_data_out = 0, stay IDLE.
REQ-022 IDLE, in_valid, memory op, aligned: latch all inputs, go to REQ.
REQ-023 REQ: mem_req_valid = 1; address, wdata, wstrb and we are held stable until mem_req_ready; the handshake edge moves to WAIT.
REQ-024 WAIT: on mem_resp_valid, load outputs next edge, pulse out_valid, return to IDLE; loads and stores both wait for the response.
REQ-025 mem_resp_valid is ignored outside WAIT.
REQ-026 Minimum memory-op latency: accept edge 0, REQ cycle 1 with ready, response in cycle 2, out_valid in cycle 3; memory stalls extend it unboundedly.
REQ-027 Access size from funct3[1:0]: 00 byte, 01 half, 10 word, 11 double. funct3[2] = 1 on a load zero-extends; otherwise sign-extend.
REQ-028 Lane = addr[2:0]; load_data = mem_rdata >> (8*lane), truncated to size, then extended to 64 bits.
REQ-029 Store: wdata = rs2 low bytes shifted left by 8*lane; wstrb = size mask (0x01/0x03/0x0F/0xFF) << lane.
REQ-030 Misaligned (half addr[0], word addr[1:0], double addr[2:0] nonzero): no memory request; latency 1; misaligned_out = 1; WB_Ctrl_out = 0.
REQ-031 mem_read and mem_write both set: executes as a load; no store is issued.
REQ-032 ALU_res_out, PC_out and rd_addr_out always carry the captured inputs unmodified.
REQ-033 Outputs other than out_valid hold their last values between pulses.

Reset
REQ-034 rst forces state IDLE; out_valid, mem_req_valid, mem_we, misaligned_out and all data outputs are 0.
REQ-035 rst asserted mid-operation (REQ or WAIT) drops mem_req_valid immediately, abandons the access, and produces no out_valid.
REQ-036 The first edge after rst deassert may accept an instruction.

Verification
REQ-037 ALU op, in_valid = 1, ALU_res_in = 0x1234, rd = 5 -> next cycle out_valid = 1, ALU_res_out = 0x1234, rd_addr_out = 5, no mem_req_valid.
REQ-038 LB at addr 0x1003, mem_rdata = 0x00000000_80000000 -> mem_addr = 0x1000, load_data_out = 0xFFFFFFFF_FFFFFF80; LBU -> 0x80.
REQ-039 SH at addr 0x1006, rs2 = 0xBEEF -> mem_we = 1, wstrb = 0xC0, wdata[63:48] = 0xBEEF.
REQ-040 LW at 0x1002 -> misaligned_out = 1, WB_Ctrl_out = 0, mem_req_valid never asserted, out_valid after 1 cycle.
REQ-041 LD with mem_req_ready low for 3 cycles and response 2 cycles later -> request signals stable throughout, stall_out = 1 throughout, exactly one out_valid.
REQ-042 rst pulsed while in WAIT, then a late mem_resp_valid -> no out_valid, state IDLE, in_ready = 1.
